// File: rtl/lock_corruption_monitor_if.sv
// Vector/result bundle for the lock corruption monitor.
// The master side drives operands and sums; the slave side (the monitor) returns the scores.
interface lock_corruption_monitor_if #(
    parameter int DATA_W = 16,
    parameter int KEY_W  = 32,
    parameter int CNT_W  = 16,
    parameter int HD_W   = 24
);
    logic              start_i;
    logic [KEY_W-1:0]  key_i;
    logic              vld_i;
    logic [DATA_W-1:0] add1_i;
    logic [DATA_W-1:0] add2_i;
    logic [DATA_W:0]   lock_res_i;
    logic [DATA_W:0]   gold_res_i;
    logic              busy_o;
    logic              done_o;
    logic [KEY_W-1:0]  key_o;
    logic [CNT_W-1:0]  vec_cnt_o;
    logic [CNT_W-1:0]  mism_cnt_o;
    logic [HD_W-1:0]   hd_sum_o;
    logic [4:0]        hd_max_o;
    logic [CNT_W-1:0]  apx_cnt_o;

    modport master (
        output start_i, key_i, vld_i, add1_i, add2_i, lock_res_i, gold_res_i,
        input  busy_o, done_o, key_o, vec_cnt_o, mism_cnt_o, hd_sum_o, hd_max_o, apx_cnt_o
    );

    modport slave (
        input  start_i, key_i, vld_i, add1_i, add2_i, lock_res_i, gold_res_i,
        output busy_o, done_o, key_o, vec_cnt_o, mism_cnt_o, hd_sum_o, hd_max_o, apx_cnt_o
    );
endinterface

// File: rtl/lock_corruption_monitor.sv
// Scores a locked adder against its correct-key twin over a window of vectors:
// mismatch count, Hamming-distance total/worst case, and golden-sum approximation errors.
module lock_corruption_monitor #(
    parameter int DATA_W = 16,
    parameter int KEY_W  = 32,
    parameter int WINDOW = 5000,
    parameter int CNT_W  = 16,
    parameter int HD_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lock_corruption_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic               r_drain_cnt;
    logic               r_busy;
    logic               r_done;
    logic [KEY_W-1:0]   r_key;
    logic [CNT_W-1:0]   r_vec_cnt;

    logic               r_s1_vld;
    logic [DATA_W:0]    r_s1_xor;
    logic               r_s1_mism;
    logic               r_s1_apx;

    logic [CNT_W-1:0]   r_mism_cnt;
    logic [CNT_W-1:0]   r_apx_cnt;
    logic [HD_W-1:0]    r_hd_sum;
    logic [4:0]         r_hd_max;

    logic               w_start_ok;
    logic               w_accept;
    logic               w_last;
    logic [DATA_W:0]    w_exact;
    logic [4:0]         w_pop;
    logic [HD_W:0]      w_hd_next;

    assign w_start_ok = bus.start_i && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_accept   = (r_state == ST_RUN) && bus.vld_i;
    assign w_last     = w_accept && (r_vec_cnt == CNT_W'(WINDOW - 1));
    assign w_exact    = {1'b0, bus.add1_i} + {1'b0, bus.add2_i};

    // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred;
    // clocked blocks use only non-blocking '<='.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i <= DATA_W; i++) begin
            w_pop = w_pop + {4'b0, r_s1_xor[i]};
        end
    end

    // One extra bit catches the carry so the running total can clamp instead of wrapping.
    assign w_hd_next = {1'b0, r_hd_sum} + {{(HD_W-4){1'b0}}, w_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_key       <= '0;
            r_vec_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_key     <= bus.key_i;
                        r_vec_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_vec_cnt <= r_vec_cnt + 1'b1;
                    end
                    if (w_last) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Two drain cycles let the last vector clear both pipeline stages.
                    r_drain_cnt <= 1'b1;
                    if (r_drain_cnt) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_xor   <= '0;
            r_s1_mism  <= 1'b0;
            r_s1_apx   <= 1'b0;
            r_mism_cnt <= '0;
            r_apx_cnt  <= '0;
            r_hd_sum   <= '0;
            r_hd_max   <= '0;
        end else if (w_start_ok) begin
            r_s1_vld   <= 1'b0;
            r_mism_cnt <= '0;
            r_apx_cnt  <= '0;
            r_hd_sum   <= '0;
            r_hd_max   <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_xor  <= bus.lock_res_i ^ bus.gold_res_i;
                r_s1_mism <= |(bus.lock_res_i ^ bus.gold_res_i);
                r_s1_apx  <= (bus.gold_res_i != w_exact);
            end
            if (r_s1_vld) begin
                r_mism_cnt <= r_mism_cnt + {{(CNT_W-1){1'b0}}, r_s1_mism};
                r_apx_cnt  <= r_apx_cnt + {{(CNT_W-1){1'b0}}, r_s1_apx};
                r_hd_sum   <= w_hd_next[HD_W] ? {HD_W{1'b1}} : w_hd_next[HD_W-1:0];
                if (w_pop > r_hd_max) begin
                    r_hd_max <= w_pop;
                end
            end
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.key_o      = r_key;
    assign bus.vec_cnt_o  = r_vec_cnt;
    assign bus.mism_cnt_o = r_mism_cnt;
    assign bus.hd_sum_o   = r_hd_sum;
    assign bus.hd_max_o   = r_hd_max;
    assign bus.apx_cnt_o  = r_apx_cnt;

endmodule

// File: tb/tb_lock_corruption_monitor.sv
// Randomized bench for lock_corruption_monitor: two instances (wide and 5-bit Hamming
// accumulator) see identical stimulus and are scored against a window-level reference model.
module tb_lock_corruption_monitor;

    localparam int WIN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lock_corruption_monitor_if #(.DATA_W(16), .KEY_W(32), .CNT_W(16), .HD_W(24)) bus_a ();
    lock_corruption_monitor_if #(.DATA_W(16), .KEY_W(32), .CNT_W(16), .HD_W(5))  bus_s ();

    lock_corruption_monitor #(.DATA_W(16), .KEY_W(32), .WINDOW(WIN), .CNT_W(16), .HD_W(24)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    lock_corruption_monitor #(.DATA_W(16), .KEY_W(32), .WINDOW(WIN), .CNT_W(16), .HD_W(5)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] q_a1[$];
    logic [15:0] q_a2[$];
    logic [16:0] q_lk[$];
    logic [16:0] q_gd[$];

    task automatic drive(input logic start, input logic [31:0] key, input logic vld,
                         input logic [15:0] a1, input logic [15:0] a2,
                         input logic [16:0] lk, input logic [16:0] gd);
        bus_a.start_i = start; bus_a.key_i = key; bus_a.vld_i = vld;
        bus_a.add1_i = a1; bus_a.add2_i = a2; bus_a.lock_res_i = lk; bus_a.gold_res_i = gd;
        bus_s.start_i = start; bus_s.key_i = key; bus_s.vld_i = vld;
        bus_s.add1_i = a1; bus_s.add2_i = a2; bus_s.lock_res_i = lk; bus_s.gold_res_i = gd;
    endtask

    task automatic drive_junk(input logic start, input logic [31:0] key, input logic vld);
        drive(start, key, vld, 16'($urandom), 16'($urandom), 17'($urandom), 17'($urandom));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] exact_sum(input logic [15:0] a1, input logic [15:0] a2);
        int s;
        s = int'(a1) + int'(a2);
        return 17'(s);
    endfunction

    // Window-level reference: scores every queued vector straight from the definitions.
    task automatic model(output int e_mism, output int e_hd_a, output int e_hd_s,
                         output int e_max, output int e_apx);
        int hd;
        e_mism = 0; hd = 0; e_max = 0; e_apx = 0;
        foreach (q_lk[i]) begin
            int pc;
            pc = $countones(q_lk[i] ^ q_gd[i]);
            if (pc != 0) e_mism++;
            hd += pc;
            if (pc > e_max) e_max = pc;
            if (q_gd[i] != exact_sum(q_a1[i], q_a2[i])) e_apx++;
        end
        e_hd_a = (hd > 24'hFFFFFF) ? 24'hFFFFFF : hd;
        e_hd_s = (hd > 31) ? 31 : hd;
    endtask

    task automatic clear_q();
        q_a1.delete(); q_a2.delete(); q_lk.delete(); q_gd.delete();
    endtask

    task automatic push_vec(input logic [15:0] a1, input logic [15:0] a2,
                            input logic [16:0] lk, input logic [16:0] gd);
        q_a1.push_back(a1); q_a2.push_back(a2); q_lk.push_back(lk); q_gd.push_back(gd);
    endtask

    task automatic expect_zero(input string name);
        total++; if (bus_a.vec_cnt_o !== 16'd0)  begin bad++; $display("FAIL %s vec_cnt: got %0d want 0", name, bus_a.vec_cnt_o); end
        total++; if (bus_a.mism_cnt_o !== 16'd0) begin bad++; $display("FAIL %s mism_cnt: got %0d want 0", name, bus_a.mism_cnt_o); end
        total++; if (bus_a.hd_sum_o !== 24'd0)   begin bad++; $display("FAIL %s hd_sum: got %0d want 0", name, bus_a.hd_sum_o); end
        total++; if (bus_a.hd_max_o !== 5'd0)    begin bad++; $display("FAIL %s hd_max: got %0d want 0", name, bus_a.hd_max_o); end
        total++; if (bus_a.apx_cnt_o !== 16'd0)  begin bad++; $display("FAIL %s apx_cnt: got %0d want 0", name, bus_a.apx_cnt_o); end
        total++; if (bus_a.key_o !== 32'd0)      begin bad++; $display("FAIL %s key_o: got %h want 0", name, bus_a.key_o); end
        total++; if (bus_a.busy_o !== 1'b0)      begin bad++; $display("FAIL %s busy: got %b want 0", name, bus_a.busy_o); end
        total++; if (bus_a.done_o !== 1'b0)      begin bad++; $display("FAIL %s done: got %b want 0", name, bus_a.done_o); end
        total++; if (bus_s.hd_sum_o !== 5'd0)    begin bad++; $display("FAIL %s sat hd_sum: got %0d want 0", name, bus_s.hd_sum_o); end
    endtask

    // Runs one full window from the queued vectors; gappy toggles vld_i, mid_start pulses start_i mid-run.
    task automatic run_window(input string name, input logic [31:0] key, input bit gappy, input bit mid_start);
        int e_mism, e_hd_a, e_hd_s, e_max, e_apx;
        int idx, cyc;
        model(e_mism, e_hd_a, e_hd_s, e_max, e_apx);

        drive_junk(1'b1, key, 1'b1);
        step();
        total++; if (bus_a.busy_o !== 1'b1)  begin bad++; $display("FAIL %s start busy: got %b want 1", name, bus_a.busy_o); end
        total++; if (bus_a.key_o !== key)    begin bad++; $display("FAIL %s start key: got %h want %h", name, bus_a.key_o, key); end
        total++; if (bus_a.vec_cnt_o !== 0)  begin bad++; $display("FAIL %s start vec: got %0d want 0", name, bus_a.vec_cnt_o); end

        idx = 0; cyc = 0;
        while (idx < q_lk.size()) begin
            bit v, s;
            v = gappy ? (cyc % 2 == 0) : 1'b1;
            s = mid_start && (cyc == 3 || cyc == 4);
            if (v) drive(s, ~key, 1'b1, q_a1[idx], q_a2[idx], q_lk[idx], q_gd[idx]);
            else   drive_junk(s, ~key, 1'b0);
            step();
            if (v) idx++;
            cyc++;
            total++; if (bus_a.vec_cnt_o !== 16'(idx)) begin bad++; $display("FAIL %s vec step %0d: got %0d want %0d", name, cyc, bus_a.vec_cnt_o, idx); end
        end

        drive_junk(1'b0, key, 1'b1);
        total++; if (bus_a.done_o !== 1'b0 || bus_a.busy_o !== 1'b1) begin bad++; $display("FAIL %s drain0: done=%b busy=%b want 0/1", name, bus_a.done_o, bus_a.busy_o); end
        step();
        total++; if (bus_a.done_o !== 1'b0 || bus_a.busy_o !== 1'b1) begin bad++; $display("FAIL %s drain1: done=%b busy=%b want 0/1", name, bus_a.done_o, bus_a.busy_o); end
        step();
        total++; if (bus_a.done_o !== 1'b1)  begin bad++; $display("FAIL %s done pulse: got %b want 1", name, bus_a.done_o); end
        total++; if (bus_a.busy_o !== 1'b0)  begin bad++; $display("FAIL %s busy fall: got %b want 0", name, bus_a.busy_o); end
        total++; if (bus_a.vec_cnt_o !== 16'(WIN)) begin bad++; $display("FAIL %s vec: got %0d want %0d", name, bus_a.vec_cnt_o, WIN); end
        total++; if (bus_a.mism_cnt_o !== 16'(e_mism)) begin bad++; $display("FAIL %s mism: got %0d want %0d", name, bus_a.mism_cnt_o, e_mism); end
        total++; if (bus_a.hd_sum_o !== 24'(e_hd_a))   begin bad++; $display("FAIL %s hd_sum: got %0d want %0d", name, bus_a.hd_sum_o, e_hd_a); end
        total++; if (bus_a.hd_max_o !== 5'(e_max))     begin bad++; $display("FAIL %s hd_max: got %0d want %0d", name, bus_a.hd_max_o, e_max); end
        total++; if (bus_a.apx_cnt_o !== 16'(e_apx))   begin bad++; $display("FAIL %s apx: got %0d want %0d", name, bus_a.apx_cnt_o, e_apx); end
        total++; if (bus_a.key_o !== key)              begin bad++; $display("FAIL %s key: got %h want %h", name, bus_a.key_o, key); end
        total++; if (bus_s.hd_sum_o !== 5'(e_hd_s))    begin bad++; $display("FAIL %s sat hd_sum: got %0d want %0d", name, bus_s.hd_sum_o, e_hd_s); end
        total++; if (bus_s.hd_max_o !== 5'(e_max))     begin bad++; $display("FAIL %s sat hd_max: got %0d want %0d", name, bus_s.hd_max_o, e_max); end

        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (bus_a.done_o !== 1'b0) begin bad++; $display("FAIL %s done hold %0d: got %b want 0", name, k, bus_a.done_o); end
        end
        total++; if (bus_a.vec_cnt_o !== 16'(WIN) || bus_a.mism_cnt_o !== 16'(e_mism)) begin
            bad++; $display("FAIL %s post-done: vec=%0d mism=%0d want %0d/%0d", name, bus_a.vec_cnt_o, bus_a.mism_cnt_o, WIN, e_mism);
        end
        drive_junk(1'b0, key, 1'b0);
    endtask

    task automatic test_reset();
        drive_junk(1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) step();
        expect_zero("reset");
        rst_n = 1'b1;
        drive_junk(1'b0, 32'd0, 1'b1);
        repeat (3) step();
        expect_zero("idle_vld_ignored");
    endtask

    task automatic test_correct_key();
        clear_q();
        for (int i = 0; i < WIN; i++) begin
            logic [15:0] a1, a2;
            a1 = 16'($urandom); a2 = 16'($urandom);
            push_vec(a1, a2, exact_sum(a1, a2), exact_sum(a1, a2));
        end
        run_window("correct_key", 32'h93B4C4CF, 1'b0, 1'b0);
    endtask

    task automatic test_wrong_key();
        clear_q();
        for (int i = 0; i < WIN; i++) begin
            logic [15:0] a1, a2;
            logic [16:0] g, l;
            a1 = 16'($urandom); a2 = 16'($urandom);
            g = exact_sum(a1, a2);
            l = g;
            if (i == 0 || i == 2 || i == 5) l = g ^ 17'h00001;
            if (i == 6) l = g ^ 17'h1E000;
            push_vec(a1, a2, l, g);
        end
        run_window("wrong_key", 32'h93B4C48F, 1'b0, 1'b0);
        total++; if (bus_a.mism_cnt_o !== 16'd4 || bus_a.hd_sum_o !== 24'd7 || bus_a.hd_max_o !== 5'd4) begin
            bad++; $display("FAIL wrong_key totals: mism=%0d hd=%0d max=%0d want 4/7/4", bus_a.mism_cnt_o, bus_a.hd_sum_o, bus_a.hd_max_o);
        end
    endtask

    task automatic test_exact_sum();
        clear_q();
        push_vec(16'hFFFF, 16'hFFFF, 17'h1FFFE, 17'h1FFFE);
        push_vec(16'h0001, 16'h0001, 17'h00000, 17'h00000);
        for (int i = 2; i < WIN; i++) begin
            logic [15:0] a1, a2;
            a1 = 16'($urandom); a2 = 16'($urandom);
            push_vec(a1, a2, exact_sum(a1, a2), exact_sum(a1, a2));
        end
        run_window("exact_sum", 32'h0BADC0DE, 1'b0, 1'b0);
        total++; if (bus_a.apx_cnt_o !== 16'd1) begin bad++; $display("FAIL exact_sum apx: got %0d want 1", bus_a.apx_cnt_o); end
    endtask

    task automatic test_gappy();
        clear_q();
        for (int i = 0; i < WIN; i++) begin
            logic [16:0] g;
            g = 17'($urandom);
            push_vec(16'($urandom), 16'($urandom), g ^ 17'($urandom_range(0, 3)), g);
        end
        run_window("gappy", 32'hCAFE0001, 1'b1, 1'b1);
    endtask

    task automatic test_saturation();
        clear_q();
        for (int i = 0; i < WIN; i++) begin
            logic [16:0] g;
            g = 17'($urandom);
            push_vec(16'($urandom), 16'($urandom), ~g, g);
        end
        run_window("saturation", 32'h5A5A5A5A, 1'b0, 1'b0);
        total++; if (bus_s.hd_sum_o !== 5'd31 || bus_s.hd_max_o !== 5'd17) begin
            bad++; $display("FAIL saturation sat: hd=%0d max=%0d want 31/17", bus_s.hd_sum_o, bus_s.hd_max_o);
        end
        total++; if (bus_a.hd_sum_o !== 24'd136) begin bad++; $display("FAIL saturation wide hd: got %0d want 136", bus_a.hd_sum_o); end
    endtask

    task automatic test_reset_mid_run();
        drive_junk(1'b1, 32'h12345678, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'd0, 1'b1, 16'($urandom), 16'($urandom), 17'h1FFFF, 17'h00000);
            step();
        end
        total++; if (bus_a.vec_cnt_o !== 16'd4) begin bad++; $display("FAIL midrst pre: vec=%0d want 4", bus_a.vec_cnt_o); end
        rst_n = 1'b0;
        #1;
        expect_zero("midrst_async");
        step();
        rst_n = 1'b1;
        drive_junk(1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            total++; if (bus_a.done_o !== 1'b0 || bus_a.busy_o !== 1'b0) begin
                bad++; $display("FAIL midrst idle %0d: done=%b busy=%b want 0/0", k, bus_a.done_o, bus_a.busy_o);
            end
        end
        test_correct_key();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            clear_q();
            for (int i = 0; i < WIN; i++) begin
                logic [15:0] a1, a2;
                logic [16:0] g, l;
                a1 = 16'($urandom); a2 = 16'($urandom);
                g = ($urandom_range(0, 2) == 0) ? 17'($urandom) : exact_sum(a1, a2);
                l = ($urandom_range(0, 1) == 0) ? g : (g ^ 17'($urandom));
                push_vec(a1, a2, l, g);
            end
            run_window($sformatf("random%0d", r), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int i = 0; i < WIN; i++) begin
            logic [16:0] g;
            g = 17'($urandom);
            push_vec(16'($urandom), 16'($urandom), g ^ (17'd1 << $urandom_range(0, 16)), g);
        end
        run_window("b2b_first", 32'hAAAA5555, 1'b0, 1'b0);
        run_window("b2b_second", 32'h5555AAAA, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_correct_key();
        test_wrong_key();
        test_exact_sum();
        test_gappy();
        test_saturation();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
